// File: rtl/arb_requester.sv
// FIFO-buffered requester for one round-robin arbiter port, streaming bursts of up to MAX_BEATS.
// Optional grant-wait timeout: define ARB_REQ_TIMEOUT_EN to build the wait counter and timeout_err.

module arb_requester #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int MAX_BEATS   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       request,
  input  logic                       grant,
  output logic                       bus_valid,
  input  logic                       bus_ready,
  output logic [DATA_W-1:0]          bus_data,
  output logic                       bus_last,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t            state_q;
  logic              request_q;
  logic [BW-1:0]     beat_cnt_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic              wr_en;
  logic              beat;

  assign wr_ready   = (count_q < CW'(DEPTH));
  assign wr_en      = wr_valid && wr_ready;
  assign request    = request_q;
  assign bus_valid  = request_q && grant && (count_q != '0);
  assign beat       = bus_valid && bus_ready;
  assign bus_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  // bus_last uses the pre-edge count, so a word written alongside the last beat waits for the next tenure
  assign bus_last = bus_valid &&
                    ((beat_cnt_q == BW'(MAX_BEATS - 1)) || (count_q == CW'(1)));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (beat)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, beat})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage has no reset; stale words are unreachable once the pointers are cleared
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wait_cnt_q;
  logic          timeout_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      request_q  <= 1'b0;
      beat_cnt_q <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0) begin
            state_q    <= REQ;
            request_q  <= 1'b1;
            beat_cnt_q <= '0;
          end
        end
        REQ: begin
          if (beat) begin
            if (bus_last) begin
              state_q   <= RELEASE;
              request_q <= 1'b0;
            end else begin
              beat_cnt_q <= beat_cnt_q + BW'(1);
            end
          end
`ifdef ARB_REQ_TIMEOUT_EN
          // A timeout only fires with grant low, so it never collides with a beat
          if (grant) begin
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WW'(TIMEOUT_CYC - 1)) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b1;
            state_q    <= RELEASE;
            request_q  <= 1'b0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
          end
`endif
        end
        RELEASE: begin
          if (count_q != '0) begin
            state_q    <= REQ;
            request_q  <= 1'b1;
            beat_cnt_q <= '0;
          end else begin
            state_q    <= IDLE;
            request_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          request_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: scoreboard queue plus reference model checked every cycle,
// and per-scenario tasks with their own directed checks. Honours ARB_REQ_TIMEOUT_EN when defined.

module tb_arb_requester;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 8;
  localparam int MAX_BEATS   = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int CW          = $clog2(DEPTH) + 1;

  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_REL  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              request;
  logic              grant;
  logic              bus_valid;
  logic              bus_ready;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic [CW-1:0]     fifo_count;
  logic              timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] sb_q [$];
  int m_state = M_IDLE;
  int m_beat  = 0;
  int m_wait  = 0;
  bit m_err   = 1'b0;

  arb_requester #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .request(request), .grant(grant),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_data(bus_data), .bus_last(bus_last),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: checks outputs at the falling edge, then advances to the next rising edge
  always @(negedge clk) begin
    bit exp_req, exp_valid, exp_last, do_beat, do_wr;
    if (rst) begin
      sb_q.delete();
      m_state = M_IDLE;
      m_beat  = 0;
      m_wait  = 0;
      m_err   = 1'b0;
    end else begin
      exp_req   = (m_state == M_REQ);
      exp_valid = exp_req && grant && (sb_q.size() != 0);
      exp_last  = exp_valid && ((m_beat == MAX_BEATS - 1) || (sb_q.size() == 1));
      do_beat   = exp_valid && bus_ready;
      do_wr     = wr_valid && (sb_q.size() < DEPTH);

      n_checks++;
      if (request !== exp_req) $display("[TB] FAIL sb_request: got %b want %b at %0t", request, exp_req, $time);
      else n_pass++;
      n_checks++;
      if (bus_valid !== exp_valid) $display("[TB] FAIL sb_bus_valid: got %b want %b at %0t", bus_valid, exp_valid, $time);
      else n_pass++;
      n_checks++;
      if (bus_last !== exp_last) $display("[TB] FAIL sb_bus_last: got %b want %b at %0t", bus_last, exp_last, $time);
      else n_pass++;
      n_checks++;
      if (fifo_count !== CW'(sb_q.size())) $display("[TB] FAIL sb_fifo_count: got %0d want %0d at %0t", fifo_count, sb_q.size(), $time);
      else n_pass++;
      n_checks++;
      if (wr_ready !== (sb_q.size() < DEPTH)) $display("[TB] FAIL sb_wr_ready: got %b want %b at %0t", wr_ready, (sb_q.size() < DEPTH), $time);
      else n_pass++;
      n_checks++;
      if (timeout_err !== m_err) $display("[TB] FAIL sb_timeout_err: got %b want %b at %0t", timeout_err, m_err, $time);
      else n_pass++;
      if (exp_valid) begin
        n_checks++;
        if (bus_data !== sb_q[0]) $display("[TB] FAIL sb_bus_data: got %h want %h at %0t", bus_data, sb_q[0], $time);
        else n_pass++;
      end

      case (m_state)
        M_IDLE: if (sb_q.size() != 0) begin m_state = M_REQ; m_beat = 0; end
        M_REQ: begin
          if (do_beat) begin
            if (exp_last) m_state = M_REL;
            else m_beat++;
          end
`ifdef ARB_REQ_TIMEOUT_EN
          if (grant) m_wait = 0;
          else if (m_wait == TIMEOUT_CYC - 1) begin
            m_wait = 0; m_err = 1'b1; m_state = M_REL;
          end else m_wait++;
`endif
        end
        default: begin
          if (sb_q.size() != 0) begin m_state = M_REQ; m_beat = 0; end
          else m_state = M_IDLE;
        end
      endcase
      if (do_beat) void'(sb_q.pop_front());
      if (do_wr) sb_q.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input int n, input logic [DATA_W-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + DATA_W'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    wr_valid  = 1'b0;
    grant     = 1'b1;
    bus_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fifo_count == '0 && !request) begin ok = 1'b1; break; end
    end
    tick();
    grant = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (request !== 1'b0 || bus_valid !== 1'b0 || bus_last !== 1'b0) $display("[TB] FAIL reset_outputs: got req=%b valid=%b last=%b want 000", request, bus_valid, bus_last);
    else n_pass++;
    n_checks++;
    if (fifo_count !== '0 || wr_ready !== 1'b1 || timeout_err !== 1'b0) $display("[TB] FAIL reset_fifo: got count=%0d ready=%b terr=%b want 0/1/0", fifo_count, wr_ready, timeout_err);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if (request !== 1'b0 || fifo_count !== '0) $display("[TB] FAIL reset_release: got req=%b count=%0d want 0/0", request, fifo_count);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit ok;
    grant = 1'b1; bus_ready = 1'b1;
    wr_valid = 1'b1; wr_data = 32'hA;
    tick();
    n_checks++;
    if (request !== 1'b0) $display("[TB] FAIL basic_req_early: got %b want 0", request);
    else n_pass++;
    wr_data = 32'hB;
    tick();
    n_checks++;
    if (request !== 1'b1 || bus_valid !== 1'b1 || bus_data !== 32'hA) $display("[TB] FAIL basic_first: got req=%b valid=%b data=%h want 1/1/a", request, bus_valid, bus_data);
    else n_pass++;
    wr_data = 32'hC;
    tick();
    wr_valid = 1'b0;
    n_checks++;
    if (bus_data !== 32'hB || bus_last !== 1'b0) $display("[TB] FAIL basic_second: got data=%h last=%b want b/0", bus_data, bus_last);
    else n_pass++;
    tick();
    n_checks++;
    if (bus_data !== 32'hC || bus_last !== 1'b1) $display("[TB] FAIL basic_third: got data=%h last=%b want c/1", bus_data, bus_last);
    else n_pass++;
    tick();
    n_checks++;
    if (request !== 1'b0) $display("[TB] FAIL basic_release: got req=%b want 0", request);
    else n_pass++;
    tick();
    n_checks++;
    if (request !== 1'b0 || fifo_count !== '0) $display("[TB] FAIL basic_idle: got req=%b count=%0d want 0/0", request, fifo_count);
    else n_pass++;
    drain(ok);
  endtask

  task automatic test_burst();
    int beats = 0, first_last = 0, second_last = 0, rel = 0;
    bit ok;
    grant = 1'b0; bus_ready = 1'b1;
    push_words(6, 32'h100);
    grant = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus_valid && bus_ready) begin
        beats++;
        if (bus_last) begin
          if (first_last == 0) first_last = beats;
          else if (second_last == 0) second_last = beats;
        end
      end
      if (!request && beats == MAX_BEATS) rel++;
    end
    tick();
    n_checks++;
    if (beats != 6) $display("[TB] FAIL burst_beats: got %0d want 6", beats);
    else n_pass++;
    n_checks++;
    if (first_last != MAX_BEATS || second_last != 6) $display("[TB] FAIL burst_last_pos: got %0d,%0d want 4,6", first_last, second_last);
    else n_pass++;
    n_checks++;
    if (rel != 1) $display("[TB] FAIL burst_release_len: got %0d want 1", rel);
    else n_pass++;
    drain(ok);
  endtask

  task automatic test_full();
    logic [CW-1:0] prev;
    bit ok;
    grant = 1'b0; bus_ready = 1'b1;
    push_words(DEPTH, 32'h200);
    n_checks++;
    if (wr_ready !== 1'b0 || fifo_count !== CW'(DEPTH)) $display("[TB] FAIL full_flag: got ready=%b count=%0d want 0/8", wr_ready, fifo_count);
    else n_pass++;
    wr_valid = 1'b1; wr_data = 32'h208; grant = 1'b1;
    tick();
    n_checks++;
    if (fifo_count !== CW'(DEPTH - 1) || wr_ready !== 1'b1 || bus_valid !== 1'b1) $display("[TB] FAIL full_first_beat: got count=%0d ready=%b valid=%b want 7/1/1", fifo_count, wr_ready, bus_valid);
    else n_pass++;
    prev = fifo_count;
    tick();
    wr_valid = 1'b0;
    n_checks++;
    if (fifo_count !== prev) $display("[TB] FAIL full_simul_rw: got count=%0d want %0d", fifo_count, prev);
    else n_pass++;
    drain(ok);
    n_checks++;
    if (!ok) $display("[TB] FAIL full_drain: got not empty want empty");
    else n_pass++;
  endtask

  task automatic test_grant_toggle();
    bit [0:11] gpat;
    int beats = 0, first_last = 0, stalled = 0;
    bit ok;
    gpat = 12'b1001_1111_1111;
    grant = 1'b0; bus_ready = 1'b1;
    push_words(5, 32'h300);
    for (int i = 0; i < 12; i++) begin
      grant = gpat[i];
      @(negedge clk);
      if (!grant && bus_valid) stalled++;
      if (bus_valid && bus_ready) begin
        beats++;
        if (bus_last && first_last == 0) first_last = beats;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (stalled != 0) $display("[TB] FAIL toggle_stall: got %0d beats without grant want 0", stalled);
    else n_pass++;
    n_checks++;
    if (first_last != MAX_BEATS || beats != 5) $display("[TB] FAIL toggle_beats: got last@%0d total %0d want last@4 total 5", first_last, beats);
    else n_pass++;
    drain(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    grant = 1'b0; bus_ready = 1'b1;
    push_words(4, 32'h400);
    grant = 1'b1;
    tick();
    n_checks++;
    if (fifo_count !== CW'(3) || request !== 1'b1) $display("[TB] FAIL rstmid_pre: got count=%0d req=%b want 3/1", fifo_count, request);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (request !== 1'b0 || bus_valid !== 1'b0 || fifo_count !== '0) $display("[TB] FAIL rstmid_async: got req=%b valid=%b count=%0d want 0/0/0", request, bus_valid, fifo_count);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (request !== 1'b0 || fifo_count !== '0) $display("[TB] FAIL rstmid_idle: got req=%b count=%0d want 0/0", request, fifo_count);
      else n_pass++;
    end
    drain(ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int k = 0;
    grant = 1'b0; bus_ready = 1'b1;
    push_words(2, 32'h500);
`ifdef ARB_REQ_TIMEOUT_EN
    while (timeout_err !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    n_checks++;
    if (k != TIMEOUT_CYC) $display("[TB] FAIL timeout_cycles: got %0d want %0d", k, TIMEOUT_CYC);
    else n_pass++;
    n_checks++;
    if (request !== 1'b0 || fifo_count !== CW'(2)) $display("[TB] FAIL timeout_release: got req=%b count=%0d want 0/2", request, fifo_count);
    else n_pass++;
    tick();
    n_checks++;
    if (request !== 1'b1 || timeout_err !== 1'b1 || fifo_count !== CW'(2)) $display("[TB] FAIL timeout_retry: got req=%b terr=%b count=%0d want 1/1/2", request, timeout_err, fifo_count);
    else n_pass++;
    drain(ok);
    n_checks++;
    if (timeout_err !== 1'b1 || !ok) $display("[TB] FAIL timeout_sticky: got terr=%b drained=%b want 1/1", timeout_err, ok);
    else n_pass++;
`else
    for (k = 0; k < 100; k++) tick();
    n_checks++;
    if (timeout_err !== 1'b0 || request !== 1'b1 || fifo_count !== CW'(2)) $display("[TB] FAIL no_timeout: got terr=%b req=%b count=%0d want 0/1/2", timeout_err, request, fifo_count);
    else n_pass++;
    drain(ok);
`endif
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; grant = 1'b0; bus_ready = 1'b0;
    repeat (3) tick();
    test_reset();
    test_basic();
    test_burst();
    test_full();
    test_grant_toggle();
    test_reset_mid();
    test_timeout();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
